seq_divider_ctrl: RTL and testbench
===================================

// Module: seq_divider_ctrl
// PURPOSE
//  Multi-cycle RISC-V M-extension divider: DIV, DIVU, REM and REMU.
//  An FSM drives ONE shared AdderSubtractor_32bit instance through operand
//  negation, 32 restoring-division iterations and a sign fix-up.
//  Sits beside the EX-stage ALU; the pipeline stalls while busy is high.
// PARAMETERS
//  XLEN   32   datapath width; only 32 is supported (shared adder is 32 bit)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  start     in   1   request; accepted only in IDLE
//  op        in   2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend  in   32  rs1 value, sampled on the accept cycle
//  divisor   in   32  rs2 value, sampled on the accept cycle
//  busy      out  1   high in every state except IDLE
//  done      out  1   one-cycle pulse; result is valid in this cycle
//  result    out  32  quotient or remainder; holds until the next accept
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy, done, result
//    and all internal registers = 0.
//  - Accept: start && state==IDLE at cycle 0 latches op, dividend and divisor.
//    start while busy is ignored; there is no queueing.
//  - States and transitions:
//    IDLE -> DONE    on accept when divisor==0, or on signed overflow
//                    (DIV/REM with 0x80000000 and 0xFFFFFFFF)
//    IDLE -> ABS_A   on any other accept
//    ABS_A -> ABS_B -> ITER (x32) -> FIX -> DONE -> IDLE
//  - Normal latency: done is asserted in cycle 36. Special-case latency:
//    done is asserted in cycle 1.
//  - Shared adder control. Subtract is adder op=1 (cin=1, B inverted);
//    cout=1 means no borrow.
//    ABS_A  a_mag = 0 - dividend when signed op && dividend[31]; else pass.
//    ABS_B  b_mag = 0 - divisor under the same rule on divisor.
//    ITER   shifted = {rem[30:0], q[31]}; trial = shifted - b_mag.
//           ok = cout | rem[31], because a pre-shift MSB means a 33-bit
//           remainder greater than any divisor.
//           If ok: rem=trial, q={q[30:0],1}; else rem=shifted, q={q[30:0],0}.
//           The 5-bit counter counts 0..31; leave ITER when count==31.
//    FIX    DIV: negate q when signs differ.
//           REM: negate rem when the dividend is negative.
//           Unsigned ops pass through. Exactly one adder pass.
//  - Special results:
//    divisor==0   DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend
//    overflow     DIV -> 0x80000000; REM -> 0
//  - done pulses for 1 cycle in DONE; result is registered on entry to DONE.
//  - Reset mid-operation aborts immediately. No done is produced; the next
//    accept after release behaves normally.
//  - All adder inputs are muxed by state; no second adder or subtractor
//    exists in the block.
// STRUCTURE
//  - Shared include div_defs.vh holds:
//    op codes (OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11),
//    state encodings (IDLE, ABS_A, ABS_B, ITER, FIX, DONE),
//    DIV_ITERS=32, and INT_MIN=32'h8000_0000.
//  - One sub-module: AdderSubtractor_32bit (existing), instantiated once.
//    Its op, reg1 and reg2 are driven from the FSM mux.
// TESTING
//  1 DIVU 100/7 -> result 14, done at cycle 36. REMU 100/7 -> 2.
//  2 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF.
//  3 DIVU 0x1234/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234.
//    Both assert done at cycle 1.
//  4 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -> 0. Done at cycle 1.
//  5 DIVU 0xFFFFFFFF / 0x80000000 -> 1.
//    REMU 0xFFFFFFFF / 0x80000000 -> 0x7FFFFFFF (33-bit remainder path).
//  6 Start DIVU 50/5, pulse start again at cycle 5, assert reset_n low at
//    cycle 10 -> second start ignored, busy=0 and done never pulses.
//    Then REMU 50/6 -> 2.

Source files
------------

// File: rtl/seq_divider_ctrl_pkg.sv
// Shared definitions for the sequential RV32M divider: op codes, FSM states,
// iteration count and the signed-overflow operand.
package seq_divider_ctrl_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [4:0]  LAST_ITER = 5'(DIV_ITERS - 1);
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    ITER,
    FIX,
    DONE
  } div_state_e;

  // funct3[0] clear selects the signed variants (DIV, REM).
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // funct3[1] set selects the remainder variants (REM, REMU).
  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/seq_divider_ctrl_addsub.sv
// 32-bit adder/subtractor shared by every datapath step of the divider.
// op=1 subtracts (B inverted, carry-in 1); cout=1 then means no borrow.
module AdderSubtractor_32bit (
  input  logic        op,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  output logic [31:0] result,
  output logic        cout
);

  assign {cout, result} = {1'b0, reg1} + {1'b0, reg2 ^ {32{op}}} + {32'b0, op};

endmodule

// File: rtl/seq_divider_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: magnitude conversion, 32 restoring
// iterations and a sign fix-up, all through one shared adder/subtractor.
module seq_divider_ctrl
  import seq_divider_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state, state_nxt;
  logic [1:0]      op_q;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] q, rem, b_mag;
  logic [4:0]      cnt;

  logic            add_op, add_cout;
  logic [XLEN-1:0] add_a, add_b, add_sum;

  logic            accept, div_zero, ovf, iter_ok, fix_neg;
  logic [XLEN-1:0] shifted, fix_val, special_res;

  AdderSubtractor_32bit u_addsub (
    .op     (add_op),
    .reg1   (add_a),
    .reg2   (add_b),
    .result (add_sum),
    .cout   (add_cout)
  );

  assign accept   = start && (state == IDLE);
  assign div_zero = (divisor == '0);
  assign ovf      = is_signed_op(op) && (dividend == INT_MIN) && (divisor == '1);

  // q doubles as the dividend shift register; its MSB feeds the remainder.
  // A set remainder MSB before the shift means a 33-bit partial remainder,
  // which always exceeds the divisor even when the 32-bit subtract borrows.
  assign shifted = {rem[XLEN-2:0], q[XLEN-1]};
  assign iter_ok = add_cout | rem[XLEN-1];

  assign fix_val = is_rem_op(op_q) ? rem : q;
  assign fix_neg = is_rem_op(op_q) ? neg_a : (neg_a ^ neg_b);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = is_rem_op(op) ? dividend : '1;
    else
      special_res = is_rem_op(op) ? '0 : INT_MIN;
  end

  always_comb begin
    state_nxt = state;
    add_op    = 1'b0;
    add_a     = '0;
    add_b     = '0;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = (div_zero || ovf) ? DONE : ABS_A;
      end
      ABS_A: begin
        add_op    = 1'b1;
        add_b     = q;
        state_nxt = ABS_B;
      end
      ABS_B: begin
        add_op    = 1'b1;
        add_b     = b_mag;
        state_nxt = ITER;
      end
      ITER: begin
        add_op = 1'b1;
        add_a  = shifted;
        add_b  = b_mag;
        if (cnt == LAST_ITER)
          state_nxt = FIX;
      end
      FIX: begin
        add_op    = 1'b1;
        add_b     = fix_val;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      q      <= '0;
      rem    <= '0;
      b_mag  <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op;
            q     <= dividend;
            b_mag <= divisor;
            rem   <= '0;
            cnt   <= '0;
            neg_a <= is_signed_op(op) & dividend[XLEN-1];
            neg_b <= is_signed_op(op) & divisor[XLEN-1];
            if (div_zero || ovf)
              result <= special_res;
          end
        end
        ABS_A: if (neg_a) q <= add_sum;
        ABS_B: if (neg_b) b_mag <= add_sum;
        ITER: begin
          rem <= iter_ok ? add_sum : shifted;
          q   <= {q[XLEN-2:0], iter_ok};
          cnt <= cnt + 5'd1;
        end
        FIX:     result <= fix_neg ? add_sum : fix_val;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed and randomized checks of seq_divider_ctrl against an arithmetic
// RV32M division model, including latency, done pulse width and reset abort.
module tb_seq_divider_ctrl;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  seq_divider_ctrl #(.XLEN(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == MIN32 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : MIN32;
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? a % b : a / b;
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
    return 36;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one operation; pulse_at>0 raises start again (other operands)
  // around that cycle while busy, which must be ignored.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int pulse_at);
    logic [31:0] exp_res;
    logic [31:0] res;
    int          lat;
    exp_res = ref_result(o, a, b);
    res = 'x;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    op = o;
    dividend = a;
    divisor = b;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        res = result;
        start = 1'b0;
        break;
      end
      start = (pulse_at > 0) && (k == pulse_at - 1);
      op = 2'($urandom_range(0, 3));
      dividend = $urandom;
      divisor = $urandom;
    end
    start = 1'b0;
    check({tag, "_result"}, res, exp_res);
    check({tag, "_latency"}, 32'(lat), 32'(ref_latency(o, a, b)));
    @(negedge clk);
    check({tag, "_done_busy_after"}, {30'd0, done, busy}, 32'd0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          sel;
    logic        seen;

    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("divu_by0", 2'b01, 32'h1234, 32'd0, 0);
    do_op("remu_by0", 2'b11, 32'h1234, 32'd0, 0);
    do_op("div_ovf", 2'b00, MIN32, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf", 2'b10, MIN32, 32'hFFFF_FFFF, 0);
    do_op("divu_big", 2'b01, 32'hFFFF_FFFF, MIN32, 0);
    do_op("remu_big", 2'b11, 32'hFFFF_FFFF, MIN32, 0);
    do_op("div_neg_neg", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0);
    do_op("divu_restart_ignored", 2'b01, 32'd1000, 32'd3, 5);

    // Reset in the middle of DIVU 50/5 with a second start already ignored.
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    dividend = 32'd50;
    divisor = 32'd5;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      seen = seen | done;
      start = (k == 4);
    end
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);
    do_op("remu_after_abort", 2'b11, 32'd50, 32'd6, 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: begin ra = MIN32; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15)) ^ (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0);
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      do_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
